regfile_dbg_ctrl: RTL and testbench

Debug access controller for the core's 32x32 register file, sharing the read-port-1 and write ports between the core datapath and a host debug port driven from the PS side. On a host request it halts the core through a halt/halted handshake, performs one register read or write, acknowledges, then releases the core. It sits between the core datapath and the register file and muxes a1/a3/wd3/we3.

---
 rtl/regfile_dbg_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_regfile_dbg_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dbg_ctrl.sv
// regfile_dbg_ctrl: host debug access to the core register file.
// A host request halts the core, performs one register read or write through
// the shared a1/a3/wd3/we3 ports, acknowledges, and then releases the core.
// Optional feature macro: REGFILE_DBG_CLEAR_ON_RESET_EN. When it is defined,
// x1..x31 are zeroed after reset before host requests are accepted.
module regfile_dbg_ctrl #(
   parameter int HALT_TIMEOUT = 64,
   parameter int ADDR_W       = 5,
   parameter int DATA_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] core_a1,
   input  logic [ADDR_W-1:0] core_a3,
   input  logic [DATA_W-1:0] core_wd3,
   input  logic              core_we3,
   output logic [ADDR_W-1:0] rf_a1,
   output logic [ADDR_W-1:0] rf_a3,
   output logic [DATA_W-1:0] rf_wd3,
   output logic              rf_we3,
   input  logic [DATA_W-1:0] rf_rd1,
   output logic              core_halt_req,
   input  logic              core_halted,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic              dbg_err,
   output logic [DATA_W-1:0] dbg_rdata
);

   localparam int CNT_W = $clog2(HALT_TIMEOUT + 1);

`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT_WAIT,
      S_ACCESS,
      S_RELEASE,
      S_CLEAR
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_HALT_WAIT,
      S_ACCESS,
      S_RELEASE
   } state_t;
`endif

   state_t              state_q, state_d;
   logic                halt_req_q, halt_req_d;
   logic                ack_q, ack_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                lat_we_q, lat_we_d;
   logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
   // clr_pend_q makes the first cycle after reset start the zeroing sweep
   // rather than serve a host request; reset itself never drives the rf.
   logic                clr_pend_q, clr_pend_d;
   logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
`endif

   // Next-state and registered-output logic of the access sequencer.
   always_comb begin
      state_d     = state_q;
      halt_req_d  = halt_req_q;
      ack_d       = 1'b0;
      err_d       = err_q;
      rdata_d     = rdata_q;
      cnt_d       = cnt_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
      clr_pend_d  = clr_pend_q;
      clr_idx_d   = clr_idx_q;
`endif
      case (state_q)
         S_IDLE: begin
`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
            if (clr_pend_q) begin
               clr_pend_d = 1'b0;
               clr_idx_d  = ADDR_W'(1);
               halt_req_d = 1'b1;
               state_d    = S_CLEAR;
            end else
`endif
            if (dbg_req) begin
               lat_we_d    = dbg_we;
               lat_addr_d  = dbg_addr;
               lat_wdata_d = dbg_wdata;
               halt_req_d  = 1'b1;
               cnt_d       = '0;
               state_d     = S_HALT_WAIT;
            end
         end
         S_HALT_WAIT: begin
            if (core_halted) begin
               state_d = S_ACCESS;
            end else if (cnt_q == CNT_W'(HALT_TIMEOUT - 1)) begin
               // Give up: report the error, keep the previous read data.
               ack_d   = 1'b1;
               err_d   = 1'b1;
               state_d = S_RELEASE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_ACCESS: begin
            // rf_rd1 already reflects the latched address through rf_a1.
            if (!lat_we_q) begin
               rdata_d = rf_rd1;
            end
            ack_d   = 1'b1;
            err_d   = 1'b0;
            state_d = S_RELEASE;
         end
         S_RELEASE: begin
            // Wait for the host to drop its level request so it cannot retrigger.
            halt_req_d = 1'b0;
            if (!dbg_req) begin
               state_d = S_IDLE;
            end
         end
`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
         S_CLEAR: begin
            if (clr_idx_q == '1) begin
               halt_req_d = 1'b0;
               state_d    = S_IDLE;
            end else begin
               clr_idx_d = clr_idx_q + ADDR_W'(1);
            end
         end
`endif
         default: begin
            halt_req_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset aborts any access without an ack.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         halt_req_q  <= 1'b0;
         ack_q       <= 1'b0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         cnt_q       <= '0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
         clr_pend_q  <= 1'b1;
         clr_idx_q   <= ADDR_W'(1);
`endif
      end else begin
         state_q     <= state_d;
         halt_req_q  <= halt_req_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         cnt_q       <= cnt_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
         clr_pend_q  <= clr_pend_d;
         clr_idx_q   <= clr_idx_d;
`endif
      end
   end

   // Register-file port mux: core pass-through except during debug-owned states.
   always_comb begin
      rf_a1  = core_a1;
      rf_a3  = core_a3;
      rf_wd3 = core_wd3;
      rf_we3 = core_we3;
      if (state_q == S_ACCESS) begin
         // Driven from registers, so stable well before the rf negedge write.
         rf_a1  = lat_addr_q;
         rf_a3  = lat_addr_q;
         rf_wd3 = lat_wdata_q;
         rf_we3 = lat_we_q & (lat_addr_q != '0);
      end
`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
      else if (state_q == S_CLEAR) begin
         rf_a3  = clr_idx_q;
         rf_wd3 = '0;
         rf_we3 = 1'b1;
      end
`endif
   end

   assign core_halt_req = halt_req_q;
   assign dbg_ack       = ack_q;
   assign dbg_err       = err_q;
   assign dbg_rdata     = rdata_q;

endmodule

// File: tb/tb_regfile_dbg_ctrl.sv
// Testbench for regfile_dbg_ctrl: a behavioural register file plus a cycle
// model of each host transaction derived from the access rules (request cycle,
// halt wait, one access cycle, ack, release).
module tb_regfile_dbg_ctrl;

   localparam int HT = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  core_a1, core_a3;
   logic [31:0] core_wd3;
   logic        core_we3;
   logic [4:0]  rf_a1, rf_a3;
   logic [31:0] rf_wd3;
   logic        rf_we3;
   logic [31:0] rf_rd1;
   logic        core_halt_req;
   logic        core_halted;
   logic        dbg_req, dbg_we;
   logic [4:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ack, dbg_err;
   logic [31:0] dbg_rdata;

   int          checks = 0;
   int          failures = 0;
   logic [31:0] mem     [32];
   logic [31:0] exp_mem [32];
   logic [31:0] exp_rdata;

   always #5 clk = ~clk;

   regfile_dbg_ctrl #(.HALT_TIMEOUT(HT), .ADDR_W(5), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .core_a1(core_a1), .core_a3(core_a3), .core_wd3(core_wd3), .core_we3(core_we3),
      .rf_a1(rf_a1), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .rf_we3(rf_we3), .rf_rd1(rf_rd1),
      .core_halt_req(core_halt_req), .core_halted(core_halted),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata)
   );

   // Register file: combinational read, x0 forced to zero, write on negedge.
   assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : mem[rf_a1];
   always @(negedge clk) begin
      if (rf_we3 && rf_a3 != 5'd0) mem[rf_a3] = rf_wd3;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One host transaction. halt_at: first cycle (counted from the request
   // cycle 0) in which core_halted is high; beyond HT means never.
   task automatic run_access(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                             input int halt_at, input int hold, input bit core_wr);
      int          h, acc_c, ack_c, drop_c;
      bit          tmo;
      logic [31:0] rd_val;
      logic [4:0]  e_a1, e_a3;
      logic [31:0] e_wd3;
      logic        e_we3;
      h      = (halt_at < 1) ? 1 : halt_at;
      tmo    = (h > HT);
      acc_c  = tmo ? -1 : h + 1;
      ack_c  = tmo ? HT + 1 : h + 2;
      drop_c = ack_c + 1 + hold;
      rd_val = exp_rdata;
      for (int c = 0; c <= drop_c + 1; c++) begin
         if (c > 0) tick();
         dbg_req     = (c < drop_c);
         dbg_we      = we;
         dbg_addr    = addr;
         dbg_wdata   = wdata;
         core_halted = (c >= halt_at) && (c <= ack_c);
         core_a1     = 5'($urandom);
         core_a3     = 5'($urandom);
         core_wd3    = $urandom;
         core_we3    = (c == acc_c) ? 1'b1 :
                       (core_wr && c >= 1 && !core_halted && ($urandom_range(1, 0) == 1));
         #1;
         if (c == acc_c && !we) rd_val = (addr == 5'd0) ? 32'd0 : exp_mem[addr];
         if (c == ack_c && !tmo && !we) exp_rdata = rd_val;
         chk("halt_req", core_halt_req, (c >= 1 && c <= ack_c));
         chk("ack", dbg_ack, (c == ack_c));
         if (c == ack_c) chk("err", dbg_err, tmo);
         chk("rdata", dbg_rdata, exp_rdata);
         if (c == acc_c) begin
            e_a1 = addr; e_a3 = addr; e_wd3 = wdata; e_we3 = we && (addr != 5'd0);
         end else begin
            e_a1 = core_a1; e_a3 = core_a3; e_wd3 = core_wd3; e_we3 = core_we3;
         end
         chk("rf_a1", rf_a1, e_a1);
         chk("rf_a3", rf_a3, e_a3);
         chk("rf_wd3", rf_wd3, e_wd3);
         chk("rf_we3", rf_we3, e_we3);
         if (e_we3 && e_a3 != 5'd0) exp_mem[e_a3] = e_wd3;
      end
      core_we3    = 1'b0;
      core_halted = 1'b0;
   endtask

   // Called in the first cycle with reset released.
   task automatic post_reset_sweep();
      core_we3 = 1'b0;
      dbg_req  = 1'b0;
`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
      tick();
      for (int i = 1; i <= 31; i++) begin
         chk("clr_we3", rf_we3, 1'b1);
         chk("clr_a3", rf_a3, i);
         chk("clr_wd3", rf_wd3, 32'd0);
         chk("clr_halt", core_halt_req, 1'b1);
         exp_mem[i] = 32'd0;
         tick();
      end
      chk("clr_done_halt", core_halt_req, 1'b0);
`else
      tick();
      chk("rst_halt", core_halt_req, 1'b0);
      chk("rst_ack", dbg_ack, 1'b0);
`endif
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = $urandom;
      mem[0] = 32'd0;
      mem[6] = 32'h10;
      for (int i = 0; i < 32; i++) exp_mem[i] = mem[i];
      exp_rdata   = 32'd0;
      reset       = 1'b1;
      core_a1     = 5'd0; core_a3 = 5'd0; core_wd3 = 32'd0; core_we3 = 1'b0;
      core_halted = 1'b0;
      dbg_req     = 1'b0; dbg_we = 1'b0; dbg_addr = 5'd0; dbg_wdata = 32'd0;
      tick(); tick(); tick();
      chk("reset_halt", core_halt_req, 1'b0);
      chk("reset_ack", dbg_ack, 1'b0);
      chk("reset_err", dbg_err, 1'b0);
      chk("reset_rdata", dbg_rdata, 32'd0);
      reset = 1'b0;
      #1;
      post_reset_sweep();

      // Write with core already halted, then read it back.
      run_access(1'b1, 5'd5, 32'hDEADBEEF, 0, 0, 1'b0);
      run_access(1'b0, 5'd5, 32'd0, 0, 0, 1'b0);
      chk("read_x5", dbg_rdata, 32'hDEADBEEF);

      // Read with a slow halt handshake.
      run_access(1'b0, 5'd6, 32'd0, 4, 0, 1'b0);
      chk("read_x6", dbg_rdata, 32'h10);

      // Halt timeout: error ack, read data untouched.
      run_access(1'b0, 5'd7, 32'd0, 100000, 0, 1'b1);
      chk("tmo_rdata", dbg_rdata, 32'h10);

      // x0 write is dropped, x0 read returns zero.
      run_access(1'b1, 5'd0, 32'h1234, 0, 0, 1'b0);
      run_access(1'b0, 5'd0, 32'd0, 0, 0, 1'b0);
      chk("read_x0", dbg_rdata, 32'd0);

      // Request held long after ack must not retrigger.
      run_access(1'b0, 5'd5, 32'd0, 2, 5, 1'b0);

      // Reset during the halt wait: no ack, halt dropped next cycle.
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd9; core_halted = 1'b0; core_we3 = 1'b0;
      #1;
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk("mid_halt", core_halt_req, 1'b1);
         chk("mid_ack", dbg_ack, 1'b0);
      end
      reset = 1'b1;
      tick();
      chk("abort_halt", core_halt_req, 1'b0);
      chk("abort_ack", dbg_ack, 1'b0);
      chk("abort_rdata", dbg_rdata, 32'd0);
      exp_rdata = 32'd0;
      reset   = 1'b0;
      dbg_req = 1'b0;
      #1;
      post_reset_sweep();

`ifdef REGFILE_DBG_CLEAR_ON_RESET_EN
      run_access(1'b0, 5'd3, 32'd0, 0, 0, 1'b0);
      chk("read_x3_cleared", dbg_rdata, 32'd0);
`endif

      // Randomized transactions against the model.
      for (int n = 0; n < 24; n++) begin
         logic        r_we;
         logic [4:0]  r_addr;
         logic [31:0] r_wdata;
         int          r_halt, r_hold;
         r_we    = 1'($urandom);
         r_addr  = 5'($urandom);
         r_wdata = $urandom;
         r_halt  = ($urandom_range(7, 0) == 0) ? 1000 : int'($urandom_range(5, 0));
         r_hold  = int'($urandom_range(3, 0));
         run_access(r_we, r_addr, r_wdata, r_halt, r_hold, 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
